lsu_ctrl: RTL and testbench
===========================

LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, giving the width of the data and address paths.
REQ-002 The block SHALL have parameter MEM_LATENCY, default 1, legal range 1..4, giving the number of cycles from mem_en (read) to valid mem_rdata.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 req_valid  in  1  core requests a load or store.
REQ-006 req_ready  out  1  controller accepts a request this cycle.
REQ-007 req_we  in  1  1 = store, 0 = load.
REQ-008 req_func3  in  3  RV32I width code (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-009 req_addr  in  32  byte address.
REQ-010 req_wdata  in  32  store data, LSB-justified.
REQ-011 resp_valid  out  1  one-cycle completion pulse.
REQ-012 resp_rdata  out  32  extended load data.
REQ-013 resp_fault  out  1  misaligned or illegal request; qualified by resp_valid.
REQ-014 busy  out  1  high whenever state != IDLE.
REQ-015 mem_en  out  1  BRAM enable.
REQ-016 mem_we  out  4  BRAM byte write enables.
REQ-017 mem_addr  out  32  word-aligned address {addr[31:2],2'b00}.
REQ-018 mem_wdata  out  32  lane-positioned store data.
REQ-019 mem_rdata  in  32  BRAM read word.

Function
REQ-020 The FSM SHALL have states IDLE, WRITE, READ, WAIT and RESP.
REQ-021 req_ready SHALL equal (state == IDLE); a request is accepted on a cycle with req_valid && req_ready.
REQ-022 On acceptance, addr, func3, we and wdata SHALL be registered; inputs SHALL be ignored in all other states.
REQ-023 A fault SHALL be raised for: H/HU with addr[0]=1; W with addr[1:0]!=0; a load func3 of 011/110/111; or a store func3 other than 000/001/010.
REQ-024 A faulting request SHALL go IDLE->RESP with resp_fault=1 and resp_rdata=0, and SHALL never assert mem_en.
REQ-025 A legal store SHALL go IDLE->WRITE->RESP.
REQ-026 In WRITE, mem_en=1 for one cycle.
REQ-027 In WRITE, mem_we SHALL be: B: 0001<<addr[1:0]; H: 0011 (offset 0) or 1100 (offset 2); W: 1111.
REQ-028 In WRITE, mem_wdata SHALL be the masked byte or halfword shifted left by 8*addr[1:0], or the full word for W.
REQ-029 A legal load SHALL go IDLE->READ->WAIT->RESP.
REQ-030 READ SHALL assert mem_en=1 and mem_we=0 for one cycle.
REQ-031 WAIT SHALL last exactly MEM_LATENCY cycles, counted by an internal counter cleared on entry.
REQ-032 mem_rdata SHALL be captured on the last WAIT cycle.
REQ-033 Load extraction: B/BU select byte addr[1:0]; H/HU select halfword addr[1].
REQ-034 B and H SHALL sign-extend; BU and HU SHALL zero-extend; W SHALL pass the word through.
REQ-035 RESP SHALL assert resp_valid for exactly one cycle, then return to IDLE.
REQ-036 For stores, resp_rdata SHALL be 0 and resp_fault SHALL be 0.
REQ-037 Latency from the acceptance edge to resp_valid: store 2 cycles; fault 1 cycle; load MEM_LATENCY+2 cycles.
REQ-038 The earliest new acceptance SHALL be the cycle after RESP; there is no back-to-back overlap.
REQ-039 Outside WRITE and READ, mem_en=0, mem_we=0, and mem_addr/mem_wdata SHALL hold their last values.
REQ-040 resp_rdata and resp_fault SHALL hold their values until the next RESP.
REQ-041 mem_addr SHALL always be the word-aligned address; address wrap-around is not checked.

Reset
REQ-042 While rst_n=0, the state SHALL be IDLE.
REQ-043 While rst_n=0, the counter and all registered fields SHALL be 0.
REQ-044 While rst_n=0, resp_valid, resp_fault, busy, mem_en, mem_we, mem_addr, mem_wdata and resp_rdata SHALL be 0.
REQ-045 While rst_n=0, req_ready SHALL be 1.
REQ-046 Reset asserted mid-transaction SHALL abort it immediately with no resp_valid.
REQ-047 After a mid-transaction reset, any pending write enable SHALL drop asynchronously.

Verification
REQ-048 SB: func3=000, addr 0x1003, wdata 0xAABBCCDD -> WRITE with mem_we=1000, mem_wdata=0xDD000000, mem_addr=0x1000; resp_valid 2 cycles after acceptance.
REQ-049 LB vs LBU, MEM_LATENCY=1: mem_rdata 0x80FF7F01 at addr 0x2002 -> LB returns 0xFFFFFFFF; LBU returns 0x000000FF; resp_valid 3 cycles after acceptance.
REQ-050 LH at addr 0x2002, mem_rdata 0x80FF7F01, MEM_LATENCY=3 -> resp_rdata 0xFFFF80FF after 5 cycles; mem_en high exactly one cycle.
REQ-051 LW at 0x2001 and SH at 0x2003 -> resp_fault=1 one cycle after acceptance; mem_en never asserted.
REQ-052 req_valid held high for 3 back-to-back SW requests -> accepts spaced 3 cycles apart; req_ready=0 while busy.
REQ-053 rst_n dropped during WAIT of an LW -> all outputs 0 immediately, no resp_valid; after release, a new request is accepted normally.

Source files
------------

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: RV32I load/store controller driving one BRAM port with fixed read latency.
// Ports: req_* core request, resp_* completion pulse/data/fault, busy, mem_* BRAM port.
module lsu_ctrl #(
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_func3,
  input  logic [DATA_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_fault,
  output logic                  busy,
  output logic                  mem_en,
  output logic [3:0]            mem_we,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [2:0] {
    IDLE, WRITE, READ, WAIT, RESP
  } state_t;

  localparam logic [2:0] LAST = 3'(MEM_LATENCY - 1);

  state_t                state_q, state_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [1:0]            off_q;
  logic [2:0]            func3_q;
  logic [DATA_WIDTH-1:0] maddr_q;
  logic [DATA_WIDTH-1:0] mwdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  fault_q;

  logic                  accept;
  logic                  fault_in;
  logic                  last_wait;
  logic [DATA_WIDTH-1:0] st_data;
  logic [DATA_WIDTH-1:0] ld_data;
  logic [7:0]            ld_b;
  logic [15:0]           ld_h;
  logic [3:0]            be;

  assign accept    = req_valid && (state_q == IDLE);
  assign last_wait = (state_q == WAIT) && (cnt_q == LAST);

  // Stores only allow B/H/W; BU/HU are load-only.
  always_comb begin
    fault_in = 1'b1;
    case (req_func3)
      3'b000:         fault_in = 1'b0;
      3'b001:         fault_in = req_addr[0];
      3'b010:         fault_in = |req_addr[1:0];
      3'b100, 3'b101: fault_in = req_we
                               | (req_func3[0] & req_addr[0]);
      default:        fault_in = 1'b1;
    endcase
  end

  always_comb begin
    st_data = req_wdata;
    case (req_func3[1:0])
      2'b00: st_data = DATA_WIDTH'(req_wdata[7:0])
                       << {req_addr[1:0], 3'b000};
      2'b01: st_data = DATA_WIDTH'(req_wdata[15:0])
                       << {req_addr[1:0], 3'b000};
      default: st_data = req_wdata;
    endcase
  end

  always_comb begin
    be = 4'b1111;
    case (func3_q[1:0])
      2'b00:   be = 4'b0001 << off_q;
      2'b01:   be = 4'b0011 << off_q;
      default: be = 4'b1111;
    endcase
  end

  assign ld_b = 8'(mem_rdata >> {off_q, 3'b000});
  assign ld_h = 16'(mem_rdata >> {off_q[1], 4'b0000});

  always_comb begin
    ld_data = mem_rdata;
    case (func3_q)
      3'b000:  ld_data = {{(DATA_WIDTH-8){ld_b[7]}}, ld_b};
      3'b001:  ld_data = {{(DATA_WIDTH-16){ld_h[15]}}, ld_h};
      3'b100:  ld_data = DATA_WIDTH'(ld_b);
      3'b101:  ld_data = DATA_WIDTH'(ld_h);
      default: ld_data = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_en     = 1'b0;
    mem_we     = 4'b0000;
    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (accept) begin
          if (fault_in)    state_d = RESP;
          else if (req_we) state_d = WRITE;
          else             state_d = READ;
        end
      end
      WRITE: begin
        mem_en  = 1'b1;
        mem_we  = be;
        state_d = RESP;
      end
      READ: begin
        mem_en  = 1'b1;
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (last_wait) state_d = RESP;
        else           cnt_d   = cnt_q + 3'd1;
      end
      RESP: begin
        resp_valid = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Response fields are written on the edge that enters RESP and
  // then hold until the next RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      off_q    <= '0;
      func3_q  <= '0;
      maddr_q  <= '0;
      mwdata_q <= '0;
      rdata_q  <= '0;
      fault_q  <= 1'b0;
    end else begin
      if (accept) begin
        off_q   <= req_addr[1:0];
        func3_q <= req_func3;
        if (fault_in) begin
          rdata_q <= '0;
          fault_q <= 1'b1;
        end else begin
          maddr_q <= {req_addr[DATA_WIDTH-1:2], 2'b00};
          if (req_we) mwdata_q <= st_data;
        end
      end
      if (state_q == WRITE) begin
        rdata_q <= '0;
        fault_q <= 1'b0;
      end
      if (last_wait) begin
        rdata_q <= ld_data;
        fault_q <= 1'b0;
      end
    end
  end

  assign busy       = (state_q != IDLE);
  assign mem_addr   = maddr_q;
  assign mem_wdata  = mwdata_q;
  assign resp_rdata = rdata_q;
  assign resp_fault = fault_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: two lsu_ctrl instances (latency 1 and 3) sharing stimulus,
// checked against a transaction-level reference model.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  req_func3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] mem_rdata;

  logic        rdy[2];
  logic        rv[2];
  logic        rf[2];
  logic        bsy[2];
  logic        men[2];
  logic [3:0]  mwe[2];
  logic [31:0] rrd[2];
  logic [31:0] mad[2];
  logic [31:0] mwd[2];

  int n_chk = 0;
  int n_fail = 0;

  logic [31:0] last_ad;
  logic [31:0] last_wd;
  logic [31:0] obs_rd[2];
  logic [3:0]  obs_we[2];
  logic [31:0] obs_wd[2];

  always #5 clk = ~clk;

  lsu_ctrl #(.DATA_WIDTH(32), .MEM_LATENCY(1)) u_l1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(rdy[0]),
    .req_we(req_we), .req_func3(req_func3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(rv[0]), .resp_rdata(rrd[0]),
    .resp_fault(rf[0]), .busy(bsy[0]),
    .mem_en(men[0]), .mem_we(mwe[0]),
    .mem_addr(mad[0]), .mem_wdata(mwd[0]),
    .mem_rdata(mem_rdata)
  );

  lsu_ctrl #(.DATA_WIDTH(32), .MEM_LATENCY(3)) u_l3 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(rdy[1]),
    .req_we(req_we), .req_func3(req_func3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(rv[1]), .resp_rdata(rrd[1]),
    .resp_fault(rf[1]), .busy(bsy[1]),
    .mem_en(men[1]), .mem_we(mwe[1]),
    .mem_addr(mad[1]), .mem_wdata(mwd[1]),
    .mem_rdata(mem_rdata)
  );

  function automatic int dut_lat(int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic logic ref_fault(logic we, logic [2:0] f3,
                                     logic [31:0] a);
    int sz;
    if (we && f3 > 3'd2) return 1'b1;
    if (!we && (f3 == 3 || f3 == 6 || f3 == 7)) return 1'b1;
    sz = (f3[1:0] == 0) ? 1 : (f3[1:0] == 1) ? 2 : 4;
    return (a % sz) != 0;
  endfunction

  function automatic logic [3:0] ref_be(logic [2:0] f3,
                                        logic [31:0] a);
    int sz;
    sz = (f3[1:0] == 0) ? 1 : (f3[1:0] == 1) ? 2 : 4;
    return 4'(((1 << sz) - 1) << (a % 4));
  endfunction

  function automatic logic [31:0] ref_wd(logic [2:0] f3,
                                         logic [31:0] a,
                                         logic [31:0] wd);
    int sh;
    sh = 8 * int'(a % 4);
    if (f3[1:0] == 0) return (wd & 32'hFF) << sh;
    if (f3[1:0] == 1) return (wd & 32'hFFFF) << sh;
    return wd;
  endfunction

  function automatic logic [31:0] ref_rd(logic [2:0] f3,
                                         logic [31:0] a,
                                         logic [31:0] rd);
    logic [31:0] b;
    logic [31:0] h;
    b = (rd >> (8 * int'(a % 4))) & 32'hFF;
    h = (a % 4 >= 2) ? (rd >> 16) : (rd & 32'hFFFF);
    case (f3)
      3'd0: return (b >= 128) ? (b | 32'hFFFFFF00) : b;
      3'd1: return (h >= 32768) ? (h | 32'hFFFF0000) : h;
      3'd4: return b;
      3'd5: return h;
      default: return rd;
    endcase
  endfunction

  task automatic run_txn(input string nm, input logic we,
                         input logic [2:0] f3,
                         input logic [31:0] a,
                         input logic [31:0] wd,
                         input logic [31:0] rd);
    logic xf;
    int lat[2];
    int en_n[2];
    int rv_n[2];
    int el;
    logic [3:0]  s_we[2];
    logic [31:0] s_wd[2];
    logic [31:0] s_ad[2];
    logic [31:0] s_rd[2];
    logic        s_f[2];
    logic [31:0] e_rd;
    xf = ref_fault(we, f3, a);
    for (int k = 0; k < 2; k++) begin
      lat[k] = 0; en_n[k] = 0; rv_n[k] = 0;
      s_we[k] = '0; s_wd[k] = '0; s_ad[k] = '0;
      s_rd[k] = '0; s_f[k] = 1'b0;
    end
    req_valid = 1'b1;
    req_we    = we;
    req_func3 = f3;
    req_addr  = a;
    req_wdata = wd;
    mem_rdata = rd;
    for (int k = 0; k < 2; k++) begin
      n_chk++;
      if (rdy[k] !== 1'b1) begin
        n_fail++;
        $display("FAIL %s dut%0d ready got %b exp 1", nm, k, rdy[k]);
      end
    end
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
      req_we    = 1'($urandom);
      req_func3 = 3'($urandom);
      req_addr  = $urandom;
      req_wdata = $urandom;
      for (int k = 0; k < 2; k++) begin
        if (men[k]) begin
          en_n[k]++;
          s_we[k] = mwe[k];
          s_wd[k] = mwd[k];
          s_ad[k] = mad[k];
        end
        if (rv[k]) begin
          rv_n[k]++;
          if (lat[k] == 0) lat[k] = c;
          s_rd[k] = rrd[k];
          s_f[k]  = rf[k];
        end
      end
    end
    if (!xf) begin
      last_ad = a & 32'hFFFFFFFC;
      if (we) last_wd = ref_wd(f3, a, wd);
    end
    e_rd = (xf || we) ? 32'h0 : ref_rd(f3, a, rd);
    for (int k = 0; k < 2; k++) begin
      el = xf ? 1 : (we ? 2 : dut_lat(k) + 2);
      n_chk++;
      if (lat[k] != el) begin
        n_fail++;
        $display("FAIL %s dut%0d latency got %0d exp %0d",
                 nm, k, lat[k], el);
      end
      n_chk++;
      if (rv_n[k] != 1) begin
        n_fail++;
        $display("FAIL %s dut%0d resp_pulses got %0d exp 1",
                 nm, k, rv_n[k]);
      end
      n_chk++;
      if (en_n[k] != (xf ? 0 : 1)) begin
        n_fail++;
        $display("FAIL %s dut%0d mem_en_cycles got %0d exp %0d",
                 nm, k, en_n[k], xf ? 0 : 1);
      end
      if (!xf) begin
        n_chk++;
        if (s_ad[k] !== last_ad) begin
          n_fail++;
          $display("FAIL %s dut%0d mem_addr got %h exp %h",
                   nm, k, s_ad[k], last_ad);
        end
        n_chk++;
        if (s_we[k] !== (we ? ref_be(f3, a) : 4'h0)) begin
          n_fail++;
          $display("FAIL %s dut%0d mem_we got %b exp %b", nm, k,
                   s_we[k], we ? ref_be(f3, a) : 4'h0);
        end
        if (we) begin
          n_chk++;
          if (s_wd[k] !== last_wd) begin
            n_fail++;
            $display("FAIL %s dut%0d mem_wdata got %h exp %h",
                     nm, k, s_wd[k], last_wd);
          end
        end
      end
      n_chk++;
      if (s_rd[k] !== e_rd || s_f[k] !== xf) begin
        n_fail++;
        $display("FAIL %s dut%0d resp got %h/%b exp %h/%b",
                 nm, k, s_rd[k], s_f[k], e_rd, xf);
      end
      n_chk++;
      if (rrd[k] !== e_rd || rf[k] !== xf) begin
        n_fail++;
        $display("FAIL %s dut%0d resp_hold got %h/%b exp %h/%b",
                 nm, k, rrd[k], rf[k], e_rd, xf);
      end
      n_chk++;
      if (bsy[k] !== 1'b0 || men[k] !== 1'b0 || mwe[k] !== 4'h0
          || mad[k] !== last_ad || mwd[k] !== last_wd) begin
        n_fail++;
        $display("FAIL %s dut%0d idle got %b%b%b %h %h exp 000 %h %h",
                 nm, k, bsy[k], men[k], |mwe[k], mad[k], mwd[k],
                 last_ad, last_wd);
      end
      obs_rd[k] = s_rd[k];
      obs_we[k] = s_we[k];
      obs_wd[k] = s_wd[k];
    end
  endtask

  task automatic check_reset_outputs(input string nm);
    for (int k = 0; k < 2; k++) begin
      n_chk++;
      if ({rv[k], rf[k], bsy[k], men[k], mwe[k],
           rrd[k], mad[k], mwd[k]} !== 104'h0) begin
        n_fail++;
        $display("FAIL %s dut%0d outs got %b%b%b%b %h %h %h %h exp 0",
                 nm, k, rv[k], rf[k], bsy[k], men[k], mwe[k],
                 rrd[k], mad[k], mwd[k]);
      end
      n_chk++;
      if (rdy[k] !== 1'b1) begin
        n_fail++;
        $display("FAIL %s dut%0d req_ready got %b exp 1",
                 nm, k, rdy[k]);
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    last_ad = '0;
    last_wd = '0;
    @(negedge clk);
    check_reset_outputs("post_reset");
  endtask

  task automatic test_store;
    run_txn("sb", 1'b1, 3'b000, 32'h1003, 32'hAABBCCDD, 32'h0);
    n_chk++;
    if (obs_we[0] !== 4'b1000 || obs_wd[0] !== 32'hDD000000) begin
      n_fail++;
      $display("FAIL sb_vector got %b %h exp 1000 dd000000",
               obs_we[0], obs_wd[0]);
    end
    run_txn("sh", 1'b1, 3'b001, 32'h1002, 32'h11223344, 32'h0);
    n_chk++;
    if (obs_we[1] !== 4'b1100 || obs_wd[1] !== 32'h33440000) begin
      n_fail++;
      $display("FAIL sh_vector got %b %h exp 1100 33440000",
               obs_we[1], obs_wd[1]);
    end
    run_txn("sw", 1'b1, 3'b010, 32'h1004, 32'hCAFEBABE, 32'h0);
  endtask

  task automatic test_load_ext;
    run_txn("lb", 1'b0, 3'b000, 32'h2002, 32'h0, 32'h80FF7F01);
    n_chk++;
    if (obs_rd[0] !== 32'hFFFFFFFF) begin
      n_fail++;
      $display("FAIL lb_vector got %h exp ffffffff", obs_rd[0]);
    end
    run_txn("lbu", 1'b0, 3'b100, 32'h2002, 32'h0, 32'h80FF7F01);
    n_chk++;
    if (obs_rd[0] !== 32'h000000FF) begin
      n_fail++;
      $display("FAIL lbu_vector got %h exp 000000ff", obs_rd[0]);
    end
    run_txn("lh", 1'b0, 3'b001, 32'h2002, 32'h0, 32'h80FF7F01);
    n_chk++;
    if (obs_rd[1] !== 32'hFFFF80FF) begin
      n_fail++;
      $display("FAIL lh_vector got %h exp ffff80ff", obs_rd[1]);
    end
    run_txn("lhu", 1'b0, 3'b101, 32'h2000, 32'h0, 32'h80FF8F01);
    run_txn("lw", 1'b0, 3'b010, 32'h2008, 32'h0, 32'h80FF7F01);
  endtask

  task automatic test_fault;
    run_txn("lw_mis", 1'b0, 3'b010, 32'h2001, 32'h0, 32'h12345678);
    run_txn("sh_mis", 1'b1, 3'b001, 32'h2003, 32'h55, 32'h0);
    run_txn("ld_f3_3", 1'b0, 3'b011, 32'h2000, 32'h0, 32'h1);
    run_txn("st_f3_4", 1'b1, 3'b100, 32'h2000, 32'h7, 32'h0);
  endtask

  task automatic test_random;
    for (int i = 0; i < 120; i++) begin
      run_txn("rand", 1'($urandom), 3'($urandom),
              $urandom & 32'h0000FFFF, $urandom, $urandom);
    end
  endtask

  task automatic test_back_to_back;
    int t[3];
    int acc;
    int c;
    acc = 0;
    c = 0;
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_func3 = 3'b010;
    req_addr  = 32'h3000;
    req_wdata = 32'h12345678;
    while (acc < 3 && c < 30) begin
      for (int k = 0; k < 2; k++) begin
        n_chk++;
        if (rdy[k] !== ~bsy[k] || rdy[k] !== rdy[0]) begin
          n_fail++;
          $display("FAIL b2b dut%0d ready got %b busy %b",
                   k, rdy[k], bsy[k]);
        end
      end
      if (rdy[0]) begin
        t[acc] = c;
        acc++;
      end
      @(negedge clk);
      c++;
    end
    req_valid = 1'b0;
    n_chk++;
    if (acc != 3) begin
      n_fail++;
      $display("FAIL b2b accepts got %0d exp 3", acc);
    end else begin
      n_chk++;
      if (t[1] - t[0] != 3 || t[2] - t[1] != 3) begin
        n_fail++;
        $display("FAIL b2b spacing got %0d %0d exp 3 3",
                 t[1] - t[0], t[2] - t[1]);
      end
    end
    repeat (4) @(negedge clk);
    last_ad = 32'h3000;
    last_wd = 32'h12345678;
    for (int k = 0; k < 2; k++) begin
      n_chk++;
      if (mad[k] !== last_ad || mwd[k] !== last_wd || bsy[k]) begin
        n_fail++;
        $display("FAIL b2b_end dut%0d got %h %h %b", k,
                 mad[k], mwd[k], bsy[k]);
      end
    end
  endtask

  task automatic test_mid_reset;
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_func3 = 3'b010;
    req_addr  = 32'h2004;
    mem_rdata = 32'hCAFEF00D;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      n_chk++;
      if (bsy[k] !== 1'b1) begin
        n_fail++;
        $display("FAIL midrst dut%0d busy got %b exp 1", k, bsy[k]);
      end
    end
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        n_chk++;
        if (rv[k] !== 1'b0) begin
          n_fail++;
          $display("FAIL midrst_resp dut%0d got %b exp 0", k, rv[k]);
        end
      end
    end
    rst_n = 1'b1;
    last_ad = '0;
    last_wd = '0;
    @(negedge clk);
    run_txn("lw_after_rst", 1'b0, 3'b010, 32'h2004, 32'h0,
            32'hCAFEF00D);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_func3 = 3'b010;
    req_addr  = 32'h40;
    req_wdata = 32'hA5A5A5A5;
    @(negedge clk);
    req_valid = 1'b0;
    n_chk++;
    if (mwe[0] !== 4'hF) begin
      n_fail++;
      $display("FAIL wr_pre_rst mem_we got %b exp 1111", mwe[0]);
    end
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      n_chk++;
      if (mwe[k] !== 4'h0 || men[k] !== 1'b0) begin
        n_fail++;
        $display("FAIL wr_rst dut%0d we/en got %b/%b exp 0000/0",
                 k, mwe[k], men[k]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    last_ad = '0;
    last_wd = '0;
    @(negedge clk);
    run_txn("lb_after_rst", 1'b0, 3'b000, 32'h2001, 32'h0,
            32'h00008000);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_func3 = '0;
    req_addr  = '0;
    req_wdata = '0;
    mem_rdata = '0;
    last_ad   = '0;
    last_wd   = '0;
    test_reset;
    test_store;
    test_load_ext;
    test_fault;
    test_random;
    test_back_to_back;
    test_mid_reset;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
